mem_wb_stage: RTL
=================

# mem_wb_stage

MEM/WB pipeline stage of the core: it registers completed EX/MEM results, waits for data-memory load responses, aligns and extends load data, and drives the writeback bus (`o_wb_reg_write`, `o_wb_rd`, `o_wb_data`). That bus feeds the register file and the decode-stage forwarding unit. The forwarding unit does no x0 check, so this block guarantees that a write to x0 is never announced. It also back-pressures the pipeline while a load is outstanding.

## Interface
- `LOAD_TIMEOUT`, default 64: maximum number of WAIT cycles before a load is abandoned; 0 disables the timeout.
- `XLEN`, default 32: datapath width.

Clock and reset: one clock; reset is synchronous and active-high.
- `i_clk`  in  1  core clock
- `i_rst`  in  1  synchronous active-high reset
- `i_valid`  in  1  EX/MEM entry valid this cycle
- `i_flush`  in  1  kill the entry presented this cycle
- `i_reg_write`  in  1  instruction writes rd
- `i_rd`  in  5  destination register
- `i_mem_read`  in  1  instruction is a load
- `i_funct3`  in  3  load type
- `i_addr_lsb`  in  2  byte offset of the load address
- `i_wb_sel`  in  2  result select: 00 ALU, 01 MEM, 10 PC+4, 11 ALU
- `i_alu_result`  in  XLEN  ALU result
- `i_pc_plus4`  in  XLEN  link value
- `i_dmem_rvalid`  in  1  load data valid
- `i_dmem_rdata`  in  XLEN  raw load word
- `o_wb_reg_write`  out  1  writeback enable
- `o_wb_rd`  out  5  writeback register
- `o_wb_data`  out  XLEN  writeback data
- `o_stall`  out  1  hold upstream stages
- `o_retire`  out  1  one-cycle pulse per completed instruction
- `o_load_err`  out  1  one-cycle pulse when a load times out

## Operation
- States: IDLE and WAIT. Reset forces IDLE and sets every output and the timeout counter to 0.
- **Accept:** an entry is accepted at a clock edge when state is IDLE and `i_valid && !i_flush`.
- **No accept:** if no entry is accepted in IDLE, the next cycle has `o_wb_reg_write` = 0 and `o_retire` = 0. `o_wb_rd` and `o_wb_data` hold their values.
- **Non-load** (`i_mem_read` = 0):
  - `o_wb_reg_write` <= `i_reg_write && (i_rd != 0)`.
  - `o_wb_rd` <= `i_rd`.
  - `o_wb_data` <= the value selected by `i_wb_sel`.
  - `o_retire` <= 1.
- **Load** (`i_mem_read` = 1, overrides `i_wb_sel`): latch rd, reg_write, funct3 and addr_lsb; go to WAIT; next cycle `o_wb_reg_write` = 0.
- **WAIT:**
  - `o_stall` = 1 (combinational from state); `i_valid` and `i_flush` are ignored.
  - The counter increments every WAIT cycle.
  - On `i_dmem_rvalid`: register the aligned data, assert writeback (rd != 0 rule applies), pulse `o_retire`, return to IDLE, clear the counter.
  - If the counter reaches `LOAD_TIMEOUT` without `i_dmem_rvalid`: return to IDLE with no write and no retire, and pulse `o_load_err` next cycle.
  - `i_dmem_rvalid` on the timeout edge wins: the load completes normally.
- **Alignment by funct3:**
  - 000 LB: byte at `addr_lsb*8`, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at `addr_lsb[1]*16`, sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 and all other values: full word.
- `i_dmem_rvalid` in IDLE is ignored.
- Reset while in WAIT abandons the load silently: no `o_load_err`, no write.

## Timing
- Non-load accepted at edge N: writeback outputs valid during cycle N+1, for exactly one cycle unless a further entry is accepted.
- Load accepted at edge N with `i_dmem_rvalid` sampled at edge M > N:
  - `o_stall` is high during cycles N+1..M.
  - Writeback is valid in cycle M+1, where `o_stall` = 0.
  - The next entry is accepted at edge M+1 at the earliest, giving one bubble.
- Minimum load latency is 2 cycles, accept to writeback.
- Timeout: `o_load_err` is high in the cycle after the LOAD_TIMEOUT-th WAIT edge.

## Structure
- The shared `core_pkg` holds the `wb_sel` encodings, the load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`) and the `mem_wb_state_t` enum {IDLE, WAIT}.
- One sub-module, `load_align`: a combinational extractor taking rdata, funct3 and addr_lsb and producing the aligned `XLEN` value. It is instantiated once and is unit-testable on its own.

## Test plan
- **ALU writeback:** accept ADD rd=5, alu=0x1234, wb_sel=00 -> next cycle `o_wb_reg_write`=1, `o_wb_rd`=5, `o_wb_data`=0x00001234, `o_retire`=1; following idle cycle `o_wb_reg_write`=0.
- **x0 suppression:** accept JAL rd=0, pc_plus4=0x100 -> `o_wb_reg_write`=0, `o_retire`=1; the same instruction with rd=1 -> `o_wb_data`=0x100.
- **Load with latency 3:** LB rd=7, lsb=2, rdata=0x80FF0000 arriving 3 cycles after accept -> `o_stall` high 3 cycles, then `o_wb_data`=0xFFFFFFFF; LBU same data -> 0x000000FF; LHU lsb=2 -> 0x000080FF.
- **Stall hold:** during WAIT, drive `i_valid`=1 with rd=9 -> not accepted; it is accepted at the first edge after writeback and written one cycle later.
- **Flush and timeout:** `i_flush`=1 with `i_valid`=1 -> no write, no retire. `LOAD_TIMEOUT`=4 with no `i_dmem_rvalid` -> `o_load_err` pulses once, no write, state IDLE. `i_dmem_rvalid` on the 4th WAIT edge -> normal writeback, no error.
- **Reset mid-WAIT:** assert `i_rst` during WAIT -> all outputs 0 next cycle, no `o_load_err`, a late `i_dmem_rvalid` is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: writeback select encodings, load funct3 codes and
// the MEM/WB stage state type.
package core_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_ALU2 = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: EX/MEM entry, data-memory response and writeback outputs.
// The master side drives the entry and memory response; the slave is the stage.
interface mem_wb_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic            i_flush;
  logic            i_reg_write;
  logic [4:0]      i_rd;
  logic            i_mem_read;
  logic [2:0]      i_funct3;
  logic [1:0]      i_addr_lsb;
  logic [1:0]      i_wb_sel;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_pc_plus4;
  logic            i_dmem_rvalid;
  logic [XLEN-1:0] i_dmem_rdata;
  logic            o_wb_reg_write;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic            o_stall;
  logic            o_retire;
  logic            o_load_err;

  modport master (
    output i_valid, i_flush, i_reg_write, i_rd, i_mem_read, i_funct3, i_addr_lsb,
    output i_wb_sel, i_alu_result, i_pc_plus4, i_dmem_rvalid, i_dmem_rdata,
    input  o_wb_reg_write, o_wb_rd, o_wb_data, o_stall, o_retire, o_load_err
  );

  modport slave (
    input  i_valid, i_flush, i_reg_write, i_rd, i_mem_read, i_funct3, i_addr_lsb,
    input  i_wb_sel, i_alu_result, i_pc_plus4, i_dmem_rvalid, i_dmem_rdata,
    output o_wb_reg_write, o_wb_rd, o_wb_data, o_stall, o_retire, o_load_err
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load data extractor: picks the byte/halfword addressed by
// addr_lsb out of the raw word and sign- or zero-extends it per funct3.
module load_align
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lsb,
  output logic [XLEN-1:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr_lsb)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  aligned = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  aligned = {{(XLEN-16){1'b0}}, half_sel};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers EX/MEM results, waits on load responses with
// an optional timeout, and drives the writeback bus with x0 writes suppressed.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 64,
  parameter int unsigned XLEN         = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_wb_stage_if.slave bus
);

  localparam int unsigned CntW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;
  // Count value seen on the LOAD_TIMEOUT-th WAIT edge (counter starts at 0).
  localparam logic [CntW-1:0] LastCnt = CntW'((LOAD_TIMEOUT == 0) ? 0 : LOAD_TIMEOUT - 1);

  mem_wb_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            ld_we_q, ld_we_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_lsb_q, ld_lsb_d;

  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            retire_q, retire_d;
  logic            load_err_q, load_err_d;

  logic            accept;
  logic            timeout_hit;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] aligned;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata   (bus.i_dmem_rdata),
    .funct3  (ld_f3_q),
    .addr_lsb(ld_lsb_q),
    .aligned (aligned)
  );

  assign accept      = bus.i_valid && !bus.i_flush;
  assign timeout_hit = (LOAD_TIMEOUT != 0) && (cnt_q == LastCnt);

  always_comb begin
    case (bus.i_wb_sel)
      WB_SEL_PC4: sel_data = bus.i_pc_plus4;
      default:    sel_data = bus.i_alu_result;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_lsb_d   = ld_lsb_q;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    retire_d   = 1'b0;
    load_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.i_mem_read) begin
            state_d  = WAIT;
            cnt_d    = '0;
            ld_rd_d  = bus.i_rd;
            ld_we_d  = bus.i_reg_write;
            ld_f3_d  = bus.i_funct3;
            ld_lsb_d = bus.i_addr_lsb;
          end else begin
            wb_we_d   = bus.i_reg_write && (bus.i_rd != 5'd0);
            wb_rd_d   = bus.i_rd;
            wb_data_d = sel_data;
            retire_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the timeout edge still completes the load.
        if (bus.i_dmem_rvalid) begin
          state_d   = IDLE;
          cnt_d     = '0;
          wb_we_d   = ld_we_q && (ld_rd_q != 5'd0);
          wb_rd_d   = ld_rd_q;
          wb_data_d = aligned;
          retire_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          cnt_d      = '0;
          load_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= '0;
      ld_lsb_q   <= '0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      retire_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_f3_q    <= ld_f3_d;
      ld_lsb_q   <= ld_lsb_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      retire_q   <= retire_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.o_stall        = (state_q == WAIT);
  assign bus.o_wb_reg_write = wb_we_q;
  assign bus.o_wb_rd        = wb_rd_q;
  assign bus.o_wb_data      = wb_data_q;
  assign bus.o_retire       = retire_q;
  assign bus.o_load_err     = load_err_q;

endmodule
